// File: rtl/i2c_cmd_seq_if.sv
// Bus bundle between the command sequencer, its external command ROM and the i2c_master.
interface i2c_cmd_seq_if #(
    parameter int ROM_AW = 6
);
    logic              rom_rd_en;
    logic [ROM_AW-1:0] rom_addr;
    logic [8:0]        rom_data;
    logic              m_write_en;
    logic [6:0]        m_chip_addr;
    logic [7:0]        m_reg_addr;
    logic [7:0]        m_data;
    logic              m_done;
    logic              m_nack;

    modport master (
        output rom_rd_en, rom_addr,
        input  rom_data,
        output m_write_en, m_chip_addr, m_reg_addr, m_data,
        input  m_done, m_nack
    );

    modport slave (
        input  rom_rd_en, rom_addr,
        output rom_data,
        input  m_write_en, m_chip_addr, m_reg_addr, m_data,
        output m_done, m_nack
    );
endinterface

// File: rtl/i2c_cmd_seq.sv
// Table-driven I2C command sequencer: runs one of NUM_SEQ ROM-resident command lists per request,
// with in-table delays, a fixed inter-command gap, NACK retry and abort.
module i2c_cmd_seq #(
    parameter logic [6:0] CHIP_ADDR    = 7'h3C,
    parameter logic [7:0] CTRL_BYTE    = 8'h00,
    parameter int         NUM_SEQ      = 4,
    parameter int         ROM_AW       = 6,
    parameter int         SLEEP_CYCLES = 50000,
    parameter int         SLEEP_W      = 16,
    parameter int         DELAY_UNIT   = 250,
    parameter int         MAX_RETRY    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SEQ-1:0]        seq_req,
    input  logic [NUM_SEQ*ROM_AW-1:0] seq_base,
    input  logic [NUM_SEQ*ROM_AW-1:0] seq_len,
    input  logic                      abort,
    i2c_cmd_seq_if.master             bus,
    output logic                      busy,
    output logic                      seq_done,
    output logic [2:0]                cur_seq,
    output logic                      err,
    output logic [NUM_SEQ-1:0]        pending
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_WAIT_ROM  = 3'd2;
    localparam logic [2:0] ST_ISSUE     = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_DELAY     = 3'd5;
    localparam logic [2:0] ST_GAP       = 3'd6;
    localparam logic [2:0] ST_FINISH    = 3'd7;

    localparam int                 RC_W      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [SLEEP_W-1:0] GAP_LOAD  = SLEEP_W'(SLEEP_CYCLES - 1);
    localparam logic [RC_W-1:0]    RETRY_MAX = RC_W'(MAX_RETRY);

    logic [2:0]         state_r, state_nxt_s;
    logic [NUM_SEQ-1:0] req_meta_r, req_sync_r, req_prev_r, req_rise_s;
    logic [NUM_SEQ-1:0] pending_r, pending_nxt_s, pick_mask_s;
    logic [2:0]         pick_idx_s;
    logic [ROM_AW-1:0]  sel_base_s, sel_len_s;
    logic [ROM_AW-1:0]  ptr_r, rem_r;
    logic [SLEEP_W-1:0] cnt_r, delay_load_s;
    logic [RC_W-1:0]    retry_cnt_r;
    logic               retry_pend_r, retry_ok_s;
    logic               start_s, abort_take_s;
    logic [7:0]         m_data_r;
    logic               rd_en_r, write_en_r, busy_r, done_r, err_r;
    logic [2:0]         cur_seq_r;

    assign req_rise_s   = req_sync_r & ~req_prev_r;
    assign start_s      = (state_r == ST_IDLE) && (pending_r != {NUM_SEQ{1'b0}}) && !abort;
    assign retry_ok_s   = (retry_cnt_r < RETRY_MAX);
    assign sel_base_s   = seq_base[int'(pick_idx_s) * ROM_AW +: ROM_AW];
    assign sel_len_s    = seq_len[int'(pick_idx_s) * ROM_AW +: ROM_AW];
    assign delay_load_s = SLEEP_W'(bus.rom_data[7:0]) * SLEEP_W'(DELAY_UNIT);

    assign bus.rom_rd_en   = rd_en_r;
    assign bus.rom_addr    = ptr_r;
    assign bus.m_write_en  = write_en_r;
    assign bus.m_chip_addr = CHIP_ADDR;
    assign bus.m_reg_addr  = CTRL_BYTE;
    assign bus.m_data      = m_data_r;
    assign busy            = busy_r;
    assign seq_done        = done_r;
    assign cur_seq         = cur_seq_r;
    assign err             = err_r;
    assign pending         = pending_r;

    // Lowest-index pending request wins; scan high to low so the last hit is the lowest
    always_comb begin
        pick_idx_s  = 3'd0;
        pick_mask_s = {NUM_SEQ{1'b0}};
        for (int i = NUM_SEQ - 1; i >= 0; i--) begin
            pick_idx_s  = pending_r[i] ? 3'(i) : pick_idx_s;
            pick_mask_s = pending_r[i] ? (NUM_SEQ'(1) << i) : pick_mask_s;
        end
    end

    // Next-state decode; abort is only honoured at safe points and after m_done
    always_comb begin
        state_nxt_s  = state_r;
        abort_take_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = (sel_len_s == ROM_AW'(0)) ? ST_FINISH : ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                abort_take_s = abort;
                state_nxt_s  = abort ? ST_FINISH : ST_WAIT_ROM;
            end
            ST_WAIT_ROM:  state_nxt_s = bus.rom_data[8] ? ST_DELAY : ST_ISSUE;
            ST_ISSUE:     state_nxt_s = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (!bus.m_done) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else if (abort) begin
                    abort_take_s = 1'b1;
                    state_nxt_s  = ST_FINISH;
                end else if (!bus.m_nack || retry_ok_s) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_FINISH;
                end
            end
            ST_DELAY: begin
                abort_take_s = abort;
                if (abort) begin
                    state_nxt_s = ST_FINISH;
                end else if (cnt_r != SLEEP_W'(0)) begin
                    state_nxt_s = ST_DELAY;
                end else begin
                    state_nxt_s = (rem_r == ROM_AW'(1)) ? ST_FINISH : ST_FETCH;
                end
            end
            ST_GAP: begin
                abort_take_s = abort;
                if (abort) begin
                    state_nxt_s = ST_FINISH;
                end else if (cnt_r != SLEEP_W'(0)) begin
                    state_nxt_s = ST_GAP;
                end else if (retry_pend_r) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = (rem_r == ROM_AW'(0)) ? ST_FINISH : ST_FETCH;
                end
            end
            ST_FINISH: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Pending request bookkeeping; new edges are never lost, even during abort
    always_comb begin
        pending_nxt_s = pending_r;
        if (abort_take_s) begin
            pending_nxt_s = {NUM_SEQ{1'b0}};
        end else if (start_s) begin
            pending_nxt_s = pending_r & ~pick_mask_s;
        end else begin
            pending_nxt_s = pending_r;
        end
        pending_nxt_s = pending_nxt_s | req_rise_s;
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            req_meta_r   <= {NUM_SEQ{1'b0}};
            req_sync_r   <= {NUM_SEQ{1'b0}};
            req_prev_r   <= {NUM_SEQ{1'b0}};
            pending_r    <= {NUM_SEQ{1'b0}};
            ptr_r        <= ROM_AW'(0);
            rem_r        <= ROM_AW'(0);
            cnt_r        <= SLEEP_W'(0);
            retry_cnt_r  <= RC_W'(0);
            retry_pend_r <= 1'b0;
            m_data_r     <= 8'h00;
            rd_en_r      <= 1'b0;
            write_en_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            cur_seq_r    <= 3'd0;
        end else begin
            state_r    <= state_nxt_s;
            req_meta_r <= seq_req;
            req_sync_r <= req_meta_r;
            req_prev_r <= req_sync_r;
            pending_r  <= pending_nxt_s;
            rd_en_r    <= (state_nxt_s == ST_FETCH);
            write_en_r <= (state_nxt_s == ST_ISSUE);
            busy_r     <= (state_nxt_s != ST_IDLE);
            done_r     <= (state_nxt_s == ST_FINISH);
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        cur_seq_r    <= pick_idx_s;
                        ptr_r        <= sel_base_s;
                        rem_r        <= sel_len_s;
                        retry_cnt_r  <= RC_W'(0);
                        retry_pend_r <= 1'b0;
                        err_r        <= 1'b0;
                    end
                end
                ST_WAIT_ROM: begin
                    if (bus.rom_data[8]) begin
                        cnt_r <= delay_load_s;
                    end else begin
                        m_data_r <= bus.rom_data[7:0];
                    end
                end
                ST_ISSUE: retry_pend_r <= 1'b0;
                ST_WAIT_DONE: begin
                    if (bus.m_done) begin
                        if (!bus.m_nack) begin
                            retry_cnt_r <= RC_W'(0);
                            ptr_r       <= ptr_r + ROM_AW'(1);
                            rem_r       <= rem_r - ROM_AW'(1);
                            cnt_r       <= GAP_LOAD;
                        end else if (retry_ok_s) begin
                            retry_cnt_r  <= retry_cnt_r + RC_W'(1);
                            retry_pend_r <= 1'b1;
                            cnt_r        <= GAP_LOAD;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_DELAY: begin
                    if (cnt_r != SLEEP_W'(0)) begin
                        cnt_r <= cnt_r - SLEEP_W'(1);
                    end else begin
                        ptr_r <= ptr_r + ROM_AW'(1);
                        rem_r <= rem_r - ROM_AW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_r != SLEEP_W'(0)) begin
                        cnt_r <= cnt_r - SLEEP_W'(1);
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Scoreboard bench for i2c_cmd_seq: directed runs against a ROM model and an i2c_master model.
module tb_i2c_cmd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  seq_req;
    logic [23:0] seq_base, seq_len;
    logic        abort;
    logic        busy, seq_done, err;
    logic [2:0]  cur_seq;
    logic [3:0]  pending;

    i2c_cmd_seq_if #(.ROM_AW(6)) bus ();

    i2c_cmd_seq #(
        .CHIP_ADDR(7'h3C), .CTRL_BYTE(8'h00), .NUM_SEQ(4), .ROM_AW(6),
        .SLEEP_CYCLES(10), .SLEEP_W(16), .DELAY_UNIT(4), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .reset(reset), .seq_req(seq_req), .seq_base(seq_base), .seq_len(seq_len),
        .abort(abort), .bus(bus), .busy(busy), .seq_done(seq_done), .cur_seq(cur_seq),
        .err(err), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] data; int gap; } wr_t;
    typedef struct { logic [2:0] seq; logic err; } dn_t;

    wr_t  exp_w_q[$];
    dn_t  exp_d_q[$];
    bit   nack_q[$];
    logic [8:0] rom [0:63];
    int total = 0, bad = 0;
    int cyc = 0, last_done_cyc = 0, done_cnt = 0, rd_cnt = 0, busy_cyc = 0;
    int mst_lat = 2, mst_cnt = 0;
    bit mst_busy = 1'b0, cur_nack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [7:0] d, input int g);
        wr_t e;
        e.data = d;
        e.gap  = g;
        exp_w_q.push_back(e);
    endtask

    task automatic exp_dn(input logic [2:0] s, input logic e_err);
        dn_t e;
        e.seq = s;
        e.err = e_err;
        exp_d_q.push_back(e);
    endtask

    task automatic pulse_req(input logic [3:0] mask);
        seq_req = seq_req | mask;
        repeat (4) @(negedge clk);
        seq_req = seq_req & ~mask;
    endtask

    task automatic wait_done_cnt(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, 32'(done_cnt >= target), 32'd1);
    endtask

    // Command ROM: data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (bus.rom_rd_en) bus.rom_data <= rom[bus.rom_addr];
    end

    // i2c_master model: fixed latency, NACK pattern taken per write from nack_q
    always @(posedge clk) begin
        bus.m_done <= 1'b0;
        bus.m_nack <= 1'b0;
        if (!reset) begin
            mst_busy <= 1'b0;
        end else if (mst_busy) begin
            if (mst_cnt == 0) begin
                bus.m_done <= 1'b1;
                bus.m_nack <= cur_nack;
                mst_busy   <= 1'b0;
            end else begin
                mst_cnt <= mst_cnt - 1;
            end
        end else if (bus.m_write_en) begin
            mst_busy <= 1'b1;
            mst_cnt  <= mst_lat;
            cur_nack <= (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
        end
    end

    // Monitor: pops expected writes / completions whenever the DUT presents one
    always @(negedge clk) begin
        wr_t w;
        dn_t d;
        cyc++;
        if (reset) begin
            if (bus.m_done) last_done_cyc = cyc;
            if (bus.rom_rd_en) rd_cnt++;
            if (busy) busy_cyc++;
            if (bus.m_write_en) begin
                if (exp_w_q.size() == 0) begin
                    chk("unexpected_write", {24'h0, bus.m_data}, 32'hFFFF_FFFF);
                end else begin
                    w = exp_w_q.pop_front();
                    chk("wr_data", {24'h0, bus.m_data}, {24'h0, w.data});
                    if (w.gap >= 0) chk("wr_gap", cyc - last_done_cyc, w.gap);
                end
            end
            if (seq_done) begin
                done_cnt++;
                if (exp_d_q.size() == 0) begin
                    chk("unexpected_done", {29'h0, cur_seq}, 32'hFFFF_FFFF);
                end else begin
                    d = exp_d_q.pop_front();
                    chk("done_seq", {29'h0, cur_seq}, {29'h0, d.seq});
                    chk("done_err", {31'h0, err}, {31'h0, d.err});
                end
            end
        end
    end

    initial begin
        int n, rd0, bc0;
        reset    = 1'b0;
        seq_req  = 4'b0000;
        abort    = 1'b0;
        seq_base = {6'd8, 6'd20, 6'd16, 6'd0};
        seq_len  = {6'd5, 6'd2, 6'd1, 6'd3};
        for (int i = 0; i < 64; i++) rom[i] = 9'h000;
        rom[0] = 9'h0AE; rom[1] = 9'h0A8; rom[2] = 9'h03F;
        rom[16] = 9'h055; rom[20] = 9'h066; rom[21] = 9'h077;
        rom[8] = 9'h011; rom[9] = 9'h105; rom[10] = 9'h022; rom[11] = 9'h100; rom[12] = 9'h033;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, seq_done}, 32'd0);
        chk("rst_rd_en", {31'h0, bus.rom_rd_en}, 32'd0);
        chk("rst_wr_en", {31'h0, bus.m_write_en}, 32'd0);
        chk("rst_pending", {28'h0, pending}, 32'd0);
        chk("rst_err", {31'h0, err}, 32'd0);
        chk("rst_cur_seq", {29'h0, cur_seq}, 32'd0);
        chk("rst_m_data", {24'h0, bus.m_data}, 32'd0);
        chk("chip_addr", {25'h0, bus.m_chip_addr}, 32'h3C);
        chk("reg_addr", {24'h0, bus.m_reg_addr}, 32'h00);
        reset = 1'b1;
        @(negedge clk);

        // basic three-command run
        exp_wr(8'hAE, -1); exp_wr(8'hA8, 13); exp_wr(8'h3F, 13); exp_dn(3'd0, 1'b0);
        pulse_req(4'b0001);
        wait_done_cnt(1, "basic");
        @(negedge clk);
        chk("basic_idle", {31'h0, busy}, 32'd0);

        // simultaneous requests: lowest index first, second queued
        exp_wr(8'h55, -1); exp_wr(8'h66, -1); exp_wr(8'h77, 13);
        exp_dn(3'd1, 1'b0); exp_dn(3'd2, 1'b0);
        seq_req = 4'b0110;
        n = 0;
        while (!busy && n < 100) begin @(negedge clk); n++; end
        chk("q_cur_seq", {29'h0, cur_seq}, 32'd1);
        chk("q_pending", {28'h0, pending}, 32'b0100);
        n = 0;
        while (!seq_done && n < 200) begin @(negedge clk); n++; end
        chk("q_first_done", {31'h0, seq_done}, 32'd1);
        @(negedge clk);
        chk("q_gap_idle", {31'h0, busy}, 32'd0);
        @(negedge clk);
        chk("q_next_busy", {31'h0, busy}, 32'd1);
        chk("q_next_rd", {31'h0, bus.rom_rd_en}, 32'd1);
        chk("q_next_addr", {26'h0, bus.rom_addr}, 32'd20);
        chk("q_next_seq", {29'h0, cur_seq}, 32'd2);
        chk("q_next_pend", {28'h0, pending}, 32'd0);
        seq_req = 4'b0000;
        wait_done_cnt(3, "queue");

        // delay entries 0x105 (21 cycles) and 0x100 (1 cycle)
        exp_wr(8'h11, -1); exp_wr(8'h22, 36); exp_wr(8'h33, 16); exp_dn(3'd3, 1'b0);
        pulse_req(4'b1000);
        wait_done_cnt(4, "delay");

        // three NACKs then ACK
        nack_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_wr(8'hAE, -1); exp_wr(8'hA8, 13); exp_wr(8'hA8, 11); exp_wr(8'hA8, 11);
        exp_wr(8'hA8, 11); exp_wr(8'h3F, 13); exp_dn(3'd0, 1'b0);
        pulse_req(4'b0001);
        wait_done_cnt(5, "retry_ok");

        // four NACKs: retries exhausted
        nack_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_wr(8'hAE, -1); exp_wr(8'hA8, 13); exp_wr(8'hA8, 11); exp_wr(8'hA8, 11);
        exp_wr(8'hA8, 11); exp_dn(3'd0, 1'b1);
        pulse_req(4'b0001);
        wait_done_cnt(6, "retry_fail");
        repeat (40) @(negedge clk);
        chk("err_sticky", {31'h0, err}, 32'd1);
        chk("err_idle", {31'h0, busy}, 32'd0);

        // zero-length sequence: finish without touching the ROM
        seq_len[11:6] = 6'd0;
        rd0 = rd_cnt;
        bc0 = busy_cyc;
        exp_dn(3'd1, 1'b0);
        pulse_req(4'b0010);
        wait_done_cnt(7, "len0");
        repeat (3) @(negedge clk);
        chk("len0_no_rd", rd_cnt - rd0, 32'd0);
        chk("len0_busy_cycles", busy_cyc - bc0, 32'd1);
        seq_len[11:6] = 6'd1;

        // abort while waiting on the master
        mst_lat = 20;
        exp_wr(8'hAE, -1); exp_dn(3'd0, 1'b0);
        seq_req[0] = 1'b1;
        n = 0;
        while (!bus.m_write_en && n < 200) begin @(negedge clk); n++; end
        chk("abort_wr_seen", {31'h0, bus.m_write_en}, 32'd1);
        abort = 1'b1;
        seq_req = 4'b1000;
        repeat (4) @(negedge clk);
        chk("abort_pend_set", {28'h0, pending}, 32'b1000);
        chk("abort_still_busy", {31'h0, busy}, 32'd1);
        n = 0;
        while (!bus.m_done && n < 200) begin @(negedge clk); n++; end
        chk("abort_mdone_seen", {31'h0, bus.m_done}, 32'd1);
        chk("abort_no_early_fin", {31'h0, seq_done}, 32'd0);
        @(negedge clk);
        chk("abort_finish", {31'h0, seq_done}, 32'd1);
        chk("abort_pend_clr", {28'h0, pending}, 32'd0);
        seq_req = 4'b0000;
        repeat (5) @(negedge clk);
        abort = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_stays_idle", {31'h0, busy}, 32'd0);
        mst_lat = 2;

        // reset in the middle of a gap
        exp_wr(8'h66, -1);
        seq_req[2] = 1'b1;
        n = 0;
        while (!bus.m_done && n < 200) begin @(negedge clk); n++; end
        chk("rst_mdone_seen", {31'h0, bus.m_done}, 32'd1);
        seq_req[2] = 1'b0;
        pulse_req(4'b0001);
        chk("rst_pend_before", {28'h0, pending}, 32'b0001);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", {31'h0, busy}, 32'd0);
        chk("rst_mid_pend", {28'h0, pending}, 32'd0);
        chk("rst_mid_wr", {31'h0, bus.m_write_en}, 32'd0);
        chk("rst_mid_done", {31'h0, seq_done}, 32'd0);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("rst_no_done", done_cnt, 32'd8);
        chk("exp_wr_drained", exp_w_q.size(), 32'd0);
        chk("exp_done_drained", exp_d_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_cmd_seq.md
Name: i2c_cmd_seq

Overview:
Parametrised I2C command-sequence engine, successor to the single-table OLED init controller. Holds NUM_SEQ independent command sequences (init, all-black, all-white, interlace, …) in a shared external command ROM, each selected by a request edge. Adds queued requests, in-table delay entries, NACK retry and abort. Drives a separate i2c_master through a write_en/done handshake.

Parameters:
CHIP_ADDR, 7'h3C, 7-bit I2C slave address placed on m_chip_addr
CTRL_BYTE, 8'h00, control byte driven on m_reg_addr for every write
NUM_SEQ, 4, number of selectable sequences (1..8)
ROM_AW, 6, command ROM address width
SLEEP_CYCLES, 50000, inter-command gap in clk cycles
SLEEP_W, 16, gap/delay counter width; must hold SLEEP_CYCLES and 255*DELAY_UNIT
DELAY_UNIT, 250, clk cycles per delay-entry count
MAX_RETRY, 3, re-issues allowed per command after NACK

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
seq_req  in  NUM_SEQ  per-sequence request levels, async-safe; rising edge requests a run
seq_base  in  NUM_SEQ*ROM_AW  start address of sequence i at [i*ROM_AW +: ROM_AW]
seq_len  in  NUM_SEQ*ROM_AW  entry count of sequence i, same packing
abort  in  1  level; stop at next safe point
rom_rd_en  out  1  ROM read strobe
rom_addr  out  ROM_AW  ROM address
rom_data  in  9  entry, valid cycle after rom_rd_en; bit8=1 delay entry, bit8=0 I2C write of [7:0]
m_write_en  out  1  one-cycle write start to i2c_master
m_chip_addr  out  7  constant CHIP_ADDR
m_reg_addr  out  8  constant CTRL_BYTE
m_data  out  8  command byte
m_done  in  1  one-cycle master completion
m_nack  in  1  error flag, sampled only with m_done
busy  out  1  state != IDLE
seq_done  out  1  one-cycle pulse at end of a run
cur_seq  out  3  index of running/last sequence
err  out  1  sticky; set on retry exhaustion, cleared by next accepted request
pending  out  NUM_SEQ  latched, unserviced requests

Behaviour:
- Reset: state IDLE; all outputs 0; pending, counters, retry_cnt cleared; m_chip_addr/m_reg_addr always constant.
- seq_req double-flop synchronised; rising edge sets pending[i] in any state, including one already running (reruns once after it; multiple edges collapse to one).
- IDLE: if pending!=0 and !abort: pick lowest set index, clear its bit, cur_seq<=idx, ptr<=base, rem<=len, retry_cnt<=0, err<=0. rem==0 -> FINISH, else -> FETCH.
- FETCH (1 cycle): rom_rd_en=1, rom_addr=ptr -> WAIT_ROM.
- WAIT_ROM: latch rom_data. bit8=1 -> DELAY, count=data*DELAY_UNIT. bit8=0 -> ISSUE, m_data<=data[7:0].
- ISSUE (1 cycle): m_write_en=1 -> WAIT_DONE. m_data held until m_done.
- WAIT_DONE: on m_done & !m_nack: retry_cnt<=0, ptr++, rem-- -> GAP. On m_done & m_nack: retry_cnt<MAX_RETRY -> retry_cnt++, GAP, then ISSUE same byte without refetch; else err<=1 -> FINISH.
- DELAY: counts down; exit after count+1 cycles (data 0 = 1 cycle); ptr++, rem-- then as GAP exit, no extra gap.
- GAP: exactly SLEEP_CYCLES cycles, then: retry pending -> ISSUE; rem==0 -> FINISH; else FETCH.
- FINISH (1 cycle): seq_done=1 -> IDLE; busy low the following cycle.
- ptr increments mod 2^ROM_AW (wraps silently).
- abort: sampled in FETCH, GAP, DELAY; -> FINISH immediately, clears pending. Never interrupts WAIT_DONE; taken after m_done. Held abort blocks IDLE from starting runs.
- m_done outside WAIT_DONE ignored.
- reset mid-run: everything returns to reset values next edge; no seq_done.

Test Plan:
- Seq0 base 0 len 3, ROM {0x0AE,0x0A8,0x03F}, SLEEP_CYCLES=10, ACK all -> three m_write_en with m_data AE,A8,3F, gaps 10 cycles, one seq_done, cur_seq=0, err=0.
- Edges on seq_req[2] and seq_req[1] same cycle while idle -> seq1 runs first, pending=4'b0100 during it, seq2 starts right after FINISH.
- Entry 0x105 in seq, DELAY_UNIT=4 -> 21 cycles with no m_write_en, then next entry fetched; entry 0x100 -> 1 cycle.
- NACK on 2nd command 3 times, ACK 4th -> same m_data issued 4 times, run completes, err=0; with 4 NACKs -> err=1, seq_done, no further writes.
- abort raised during WAIT_DONE -> no FINISH until m_done, then FINISH, pending cleared; seq_len=0 request -> seq_done 2 cycles after start, no ROM read.
- reset low mid-GAP -> busy, pending, m_write_en all 0 next cycle; no seq_done.
